// File: rtl/alto_mem_pkg.sv
// Shared constants for the main-memory Wishbone arbiter: bus widths,
// watchdog counter width and the arbiter state encoding.
package alto_mem_pkg;

  localparam int WB_ADR_W = 16;
  localparam int WB_DAT_W = 16;
  localparam int WB_SEL_W = 2;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alto_rr_picker.sv
// Combinational round-robin priority encoder: scans from last_i+1 upward
// (mod N) and returns the first requester as one-hot plus its index.
module alto_rr_picker #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = '0;
    for (int off = 1; off <= N; off++) begin
      k = IW'((int'(last_i) + off) % N);
      if (!any_o && req_i[k]) begin
        gnt_o[k] = 1'b1;
        idx_o    = k;
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alto_memory_arbiter.sv
// Round-robin arbiter sharing the main-memory Wishbone slave among several
// masters; grant is held for a whole cyc, with a no-ack watchdog abort.
module alto_memory_arbiter
  import alto_mem_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [WB_ADR_W*NUM_MASTERS-1:0] m_adr_i,
  input  logic [WB_SEL_W*NUM_MASTERS-1:0] m_sel_i,
  input  logic [WB_DAT_W*NUM_MASTERS-1:0] m_dat_i,
  output logic [WB_DAT_W-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic [WB_ADR_W-1:0]             s_adr_o,
  output logic [WB_SEL_W-1:0]             s_sel_o,
  output logic [WB_DAT_W-1:0]             s_dat_o,
  input  logic [WB_DAT_W-1:0]             s_dat_i,
  input  logic                            s_ack_i,
  output logic [NUM_MASTERS-1:0]          grant_o,
  output logic                            busy_o
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] WD_LIMIT =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic                   owner_cyc;
  logic                   own;

  alto_rr_picker #(
    .N  (NUM_MASTERS),
    .IW (IDX_W)
  ) u_picker (
    .req_i  (m_cyc_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // last_q always names the current owner while one exists.
  assign own       = (state_q == ST_OWN);
  assign owner_cyc = |(m_cyc_i & grant_q);

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_dat_o = '0;
    if (own) begin
      s_cyc_o = m_cyc_i[last_q];
      s_stb_o = m_cyc_i[last_q] & m_stb_i[last_q];
      s_we_o  = m_we_i[last_q];
      s_adr_o = m_adr_i[WB_ADR_W*last_q +: WB_ADR_W];
      s_sel_o = m_sel_i[WB_SEL_W*last_q +: WB_SEL_W];
      s_dat_o = m_dat_i[WB_DAT_W*last_q +: WB_DAT_W];
    end
  end

  assign m_dat_o = s_dat_i;
  assign m_ack_o = own ? (grant_q & {NUM_MASTERS{s_ack_i}}) : '0;
  assign m_err_o = (state_q == ST_ABORT) ? grant_q : '0;
  assign grant_o = grant_q;
  assign busy_o  = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_OWN;
          grant_d = pick_gnt;
          last_d  = pick_idx;
        end
      end
      ST_OWN: begin
        if (!owner_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (WD_EN && s_stb_o && !s_ack_i) begin
          // An ack in the limit cycle bypasses this branch, so ack wins.
          if (cnt_q == WD_LIMIT) state_d = ST_ABORT;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_ABORT: begin
        if (!owner_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alto_memory_arbiter.sv
// Directed bench for alto_memory_arbiter: table-driven arbitration vectors
// plus hand sequences for beats, watchdog, ack-at-limit and async reset.
module tb_alto_memory_arbiter;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  m_cyc, m_stb, m_we;
  logic [47:0]   m_adr, m_dat;
  logic [5:0]    m_sel;
  logic [15:0]   m_dat_o;
  logic [N-1:0]  m_ack, m_err, grant;
  logic          s_cyc, s_stb, s_we, s_ack, busy;
  logic [15:0]   s_adr, s_dat_o, s_dat_i;
  logic [1:0]    s_sel;

  int tests = 0;
  int fails = 0;

  alto_memory_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(64)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_sel_i(m_sel), .m_dat_i(m_dat),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_sel_o(s_sel), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack),
    .grant_o(grant), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cyc;
    logic        ack;
    logic [15:0] sdat;
    logic [2:0]  e_grant;
    logic        e_scyc;
    logic [15:0] e_adr;
    logic [2:0]  e_ack;
    logic        e_busy;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic [2:0] cyc, logic ack, logic [15:0] sdat,
                              logic [2:0] eg, logic esc, logic [15:0] ea,
                              logic [2:0] eack, logic eb);
    vec_t v;
    v.cyc = cyc; v.ack = ack; v.sdat = sdat;
    v.e_grant = eg; v.e_scyc = esc; v.e_adr = ea; v.e_ack = eack; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(posedge clk); #1;
      m_cyc = vecs[i].cyc; m_stb = vecs[i].cyc;
      s_ack = vecs[i].ack; s_dat_i = vecs[i].sdat;
      #1;
      chk($sformatf("row%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
      chk($sformatf("row%0d_scyc", i), 32'(s_cyc), 32'(vecs[i].e_scyc));
      chk($sformatf("row%0d_adr", i), 32'(s_adr), 32'(vecs[i].e_adr));
      chk($sformatf("row%0d_ack", i), 32'(m_ack), 32'(vecs[i].e_ack));
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("row%0d_mdat", i), 32'(m_dat_o), 32'(vecs[i].sdat));
      chk($sformatf("row%0d_err", i), 32'(m_err), 32'd0);
    end
  endtask

  initial begin
    int n;
    // Single CPU read, slave acks two cycles after the grant.
    vecs[0]  = mk(3'b001, 1'b0, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000, 1'b0);
    vecs[1]  = mk(3'b001, 1'b0, 16'h0000, 3'b001, 1'b1, 16'h1234, 3'b000, 1'b1);
    vecs[2]  = mk(3'b001, 1'b0, 16'h0000, 3'b001, 1'b1, 16'h1234, 3'b000, 1'b1);
    vecs[3]  = mk(3'b001, 1'b1, 16'hBEEF, 3'b001, 1'b1, 16'h1234, 3'b001, 1'b1);
    vecs[4]  = mk(3'b000, 1'b0, 16'h0000, 3'b001, 1'b0, 16'h1234, 3'b000, 1'b1);
    vecs[5]  = mk(3'b000, 1'b0, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000, 1'b0);
    // Three simultaneous one-beat requests; row 6 also carries a spurious idle ack.
    vecs[6]  = mk(3'b111, 1'b1, 16'h1111, 3'b000, 1'b0, 16'h0000, 3'b000, 1'b0);
    vecs[7]  = mk(3'b111, 1'b1, 16'h2222, 3'b001, 1'b1, 16'h1234, 3'b001, 1'b1);
    vecs[8]  = mk(3'b110, 1'b0, 16'h0000, 3'b001, 1'b0, 16'h1234, 3'b000, 1'b1);
    vecs[9]  = mk(3'b110, 1'b0, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000, 1'b0);
    vecs[10] = mk(3'b110, 1'b1, 16'h3333, 3'b010, 1'b1, 16'h5678, 3'b010, 1'b1);
    vecs[11] = mk(3'b100, 1'b0, 16'h0000, 3'b010, 1'b0, 16'h5678, 3'b000, 1'b1);
    vecs[12] = mk(3'b100, 1'b0, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b000, 1'b0);
    vecs[13] = mk(3'b100, 1'b1, 16'h4444, 3'b100, 1'b1, 16'h9ABC, 3'b100, 1'b1);
    vecs[14] = mk(3'b000, 1'b0, 16'h0000, 3'b100, 1'b0, 16'h9ABC, 3'b000, 1'b1);

    rst_n = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0;
    m_adr = {16'h9ABC, 16'h5678, 16'h1234};
    m_dat = {16'hD002, 16'hD001, 16'hD000};
    m_sel = 6'b11_11_11;
    s_dat_i = 16'h5A5A;

    @(posedge clk); #2;
    chk("rst_scyc", 32'(s_cyc), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack_err", 32'({m_ack, m_err}), 32'd0);
    chk("rst_sadr", 32'(s_adr), 32'd0);
    chk("rst_mdat_pass", 32'(m_dat_o), 32'h5A5A);
    @(posedge clk); #1; rst_n = 1'b1;

    run_rows(0, 5);

    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    run_rows(6, 14);
    run_rows(6, 14);

    // Master 1 keeps cyc for four beats while master 0 waits.
    @(posedge clk); #1; m_cyc = 3'b010; m_stb = 3'b010; s_ack = 1'b0;
    @(posedge clk); #1; m_cyc = 3'b011; m_stb = 3'b011; #1;
    chk("hold_grant", 32'(grant), 32'b010);
    for (int b = 0; b < 4; b++) begin
      s_ack = 1'b1; #1;
      chk($sformatf("hold_beat%0d_ack", b), 32'(m_ack), 32'b010);
      @(posedge clk); #1;
    end
    s_ack = 1'b0; m_cyc = 3'b001; m_stb = 3'b001; #1;
    chk("hold_release_grant", 32'(grant), 32'b010);
    chk("hold_release_ack", 32'(m_ack), 32'b000);
    @(posedge clk); #2;
    chk("hold_dead_grant", 32'(grant), 32'b000);
    @(posedge clk); #1; s_ack = 1'b1; #1;
    chk("hold_next_grant", 32'(grant), 32'b001);
    chk("hold_next_ack", 32'(m_ack), 32'b001);
    @(posedge clk); #1; s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    @(posedge clk); #2;
    chk("hold_end_busy", 32'(busy), 32'd0);

    // Slave never acks: stb for exactly 64 cycles, then ABORT.
    @(posedge clk); #1; m_cyc = 3'b001; m_stb = 3'b001;
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #2;
      if (s_stb) n++;
      else if (n > 0) break;
    end
    chk("wd_stb_cycles", 32'(n), 32'd64);
    chk("wd_abort_scyc", 32'(s_cyc), 32'd0);
    chk("wd_abort_err", 32'(m_err), 32'b001);
    chk("wd_abort_busy", 32'(busy), 32'd1);
    chk("wd_abort_grant", 32'(grant), 32'b001);
    s_ack = 1'b1; #1;
    chk("wd_abort_ack_ignored", 32'(m_ack), 32'b000);
    @(posedge clk); #1; s_ack = 1'b0; #1;
    chk("wd_abort_err_held", 32'(m_err), 32'b001);
    @(posedge clk); #1; m_cyc = '0; m_stb = '0; #1;
    chk("wd_drop_err_still", 32'(m_err), 32'b001);
    @(posedge clk); #2;
    chk("wd_idle_err", 32'(m_err), 32'b000);
    chk("wd_idle_busy", 32'(busy), 32'd0);

    // Ack arrives in the 64th stb cycle: normal completion, no error.
    @(posedge clk); #1; m_cyc = 3'b001; m_stb = 3'b001;
    n = 0;
    for (int c = 0; c < 63; c++) begin
      @(posedge clk); #2;
      if (s_stb && m_err == 3'b000) n++;
    end
    chk("lim_pre_cycles", 32'(n), 32'd63);
    @(posedge clk); #1; s_ack = 1'b1; #1;
    chk("lim_ack", 32'(m_ack), 32'b001);
    chk("lim_err", 32'(m_err), 32'b000);
    @(posedge clk); #1; s_ack = 1'b0; #1;
    chk("lim_after_stb", 32'(s_stb), 32'd1);
    chk("lim_after_err", 32'(m_err), 32'b000);
    @(posedge clk); #1; m_cyc = '0; m_stb = '0;
    @(posedge clk); #2;
    chk("lim_idle_busy", 32'(busy), 32'd0);

    // Reset in the middle of a master-1 write.
    @(posedge clk); #1; m_cyc = 3'b010; m_stb = 3'b010; m_we = 3'b010;
    @(posedge clk); #2;
    chk("rstw_grant", 32'(grant), 32'b010);
    chk("rstw_we", 32'(s_we), 32'd1);
    chk("rstw_sdat", 32'(s_dat_o), 32'hD001);
    #2; rst_n = 1'b0; #1;
    chk("rstw_async_scyc", 32'(s_cyc), 32'd0);
    chk("rstw_async_we", 32'(s_we), 32'd0);
    chk("rstw_async_grant", 32'(grant), 32'd0);
    #2; rst_n = 1'b1; m_cyc = 3'b111; m_stb = 3'b111; m_we = '0;
    @(posedge clk); #2;
    chk("rstw_first_grant", 32'(grant), 32'b001);
    m_cyc = '0; m_stb = '0;
    @(posedge clk); @(posedge clk); #2;
    chk("rstw_end_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alto_memory_arbiter.md
Name: alto_memory_arbiter

Overview:
Shares the single main-memory Wishbone slave port among several Wishbone masters: the CPU memory interface, the display word fetcher and the disk/Ethernet DMA engines. Arbitration is round-robin with grant held for a whole bus cycle (cyc). A watchdog aborts a transfer when the slave never acknowledges. The block sits between the masters' wb_* ports and the memory controller, in the same address space (word address [16:1], 16-bit data, 2 byte selects).

Parameters:
NUM_MASTERS, 3, number of requesting masters (2..8); index 0 = CPU.
TIMEOUT_CYCLES, 64, cycles without ack before abort (1..255); 0 disables the watchdog.

Ports:
clk_i  in  1  clock.
rst_n_i  in  1  reset; one clock; reset is asynchronous and active-low.
m_cyc_i  in  NUM_MASTERS  per-master cycle request.
m_stb_i  in  NUM_MASTERS  per-master strobe.
m_we_i  in  NUM_MASTERS  per-master write enable.
m_adr_i  in  16*NUM_MASTERS  packed word addresses; master k at [16k+15:16k].
m_sel_i  in  2*NUM_MASTERS  packed byte selects.
m_dat_i  in  16*NUM_MASTERS  packed write data.
m_dat_o  out  16  read data, broadcast to all masters.
m_ack_o  out  NUM_MASTERS  per-master ack.
m_err_o  out  NUM_MASTERS  per-master timeout error.
s_cyc_o, s_stb_o, s_we_o  out  1 each  to memory slave.
s_adr_o  out  16  to slave (maps to wb_adr [16:1]).
s_sel_o  out  2  to slave.
s_dat_o  out  16  to slave.
s_dat_i  in  16  from slave.
s_ack_i  in  1  from slave.
grant_o  out  NUM_MASTERS  one-hot current owner, zero when idle.
busy_o  out  1  high in OWN or ABORT.

Behaviour:
- States: IDLE, OWN, ABORT. Reset -> IDLE, grant 0, last_grant = NUM_MASTERS-1 (master 0 wins first), timeout counter 0.
- Reset outputs: all s_* outputs 0, m_ack_o 0, m_err_o 0, grant_o 0, busy_o 0; m_dat_o = s_dat_i (pass-through, unqualified).
- IDLE: if any m_cyc_i, pick first requester scanning last_grant+1, +2, ... mod NUM_MASTERS; register grant, update last_grant, go OWN. Arbitration latency 1 cycle: request at edge N, slave sees cyc/stb after edge N+1.
- OWN: s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_sel_o/s_dat_o combinationally muxed from granted master; m_ack_o[g] = s_ack_i, others 0. Grant held while m_cyc_i[g] high (multi-beat and read-modify-write stay atomic). On m_cyc_i[g] low: next edge -> IDLE; one dead cycle between owners always.
- Non-granted masters see no ack and wait; their requests are never dropped.
- Watchdog (TIMEOUT_CYCLES>0): counter increments each OWN cycle with s_stb_o high and s_ack_i low; clears on ack, stb low, or state change. When counter reaches TIMEOUT_CYCLES-1 and no ack that cycle: next edge -> ABORT.
- ABORT: s_cyc_o = s_stb_o = 0; m_err_o[g] = 1 while in ABORT; m_ack_o = 0. Stay until m_cyc_i[g] low, then -> IDLE.
- Ack arriving in the same cycle the counter hits the limit: ack wins, no abort.
- s_ack_i while IDLE or ABORT: ignored, never forwarded.
- Granted master drops cyc while stb pending: transfer abandoned, -> IDLE, no error.
- Reset asserted mid-transfer: immediate return to reset state; s_cyc_o drops asynchronously.
- No combinational path from s_ack_i to s_cyc_o/s_stb_o.

Decomposition:
- Shared package alto_mem_pkg: WB_ADR_W=16, WB_DAT_W=16, WB_SEL_W=2, state encoding constants for IDLE/OWN/ABORT.
- One sub-module: alto_rr_picker (combinational round-robin priority encoder: requests + last_grant -> one-hot grant), reusable for the DMA request muxes.

Test Plan:
- Single CPU read: m_cyc/stb[0]=1, adr=0x1234, slave acks 2 cycles later with 0xBEEF -> s_adr_o=0x1234 one cycle after request, m_ack_o[0] pulses with m_dat_o=0xBEEF, grant_o=001 throughout, IDLE after cyc drops.
- Simultaneous requests from masters 0,1,2 after reset, each one-beat -> grant order 0,1,2 with exactly one IDLE cycle between owners; repeat burst -> order continues 0,1,2.
- Master 1 holds cyc for 4 beats while master 0 requests -> master 0 receives no ack until master 1 drops cyc, then grant_o=001.
- Slave never acks, TIMEOUT_CYCLES=64 -> s_stb_o high exactly 64 cycles, then s_cyc_o=0, m_err_o[g]=1 until master drops cyc, then IDLE; ack on cycle 64 instead -> normal ack, no err.
- Spurious s_ack_i in IDLE -> all m_ack_o stay 0.
- rst_n_i pulled low mid-write -> s_cyc_o/s_we_o 0 immediately, grant_o 0; after release master 0 is granted first.
